complex_row_multiplier: RTL and testbench

Pipelined complex multiply stage that sits directly upstream of the complex row accumulator. Each accepted beat multiplies NI matrix-row elements by NI vector elements, element-wise. It presents the NI products as one packed row to the accumulator's 8x8 adder tree. It also generates the row-valid strobe that the accumulator's control delay chain consumes, and flags the last chunk of each matrix row.

---
 rtl/complex_pkg.sv | 20 ++
 rtl/complex_row_multiplier_if.sv | 24 ++
 rtl/complex_single_multiplier.sv | 65 ++++++
 rtl/complex_row_multiplier.sv | 86 ++++++++
 tb/tb_complex_row_multiplier.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/complex_pkg.sv
// rtl/complex_pkg.sv - shared Q16.16 complex element constants, types and field extraction
package complex_pkg;

    localparam int ELEMENT_WIDTH = 64;
    localparam int PART_WIDTH    = 32;
    localparam int FRAC_BITS     = 16;
    localparam int RE_LSB        = PART_WIDTH;
    localparam int IM_LSB        = 0;

    typedef struct packed {
        logic signed [PART_WIDTH-1:0] re;
        logic signed [PART_WIDTH-1:0] im;
    } complex_t;

    // Bits [47:16] of the widened sum: floor shift with silent wrap, no saturation.
    function automatic logic [PART_WIDTH-1:0] q_field(input logic signed [2*PART_WIDTH:0] sum);
        return PART_WIDTH'(sum >>> FRAC_BITS);
    endfunction

endpackage

// File: rtl/complex_row_multiplier_if.sv
// rtl/complex_row_multiplier_if.sv - beat input and product row output bundle of the row multiplier
interface complex_row_multiplier_if #(
    parameter int NI            = 8,
    parameter int ELEMENT_WIDTH = 64
);
    logic                        start;
    logic                        in_valid;
    logic [NI*ELEMENT_WIDTH-1:0] matrix_row_input;
    logic [NI*ELEMENT_WIDTH-1:0] vector_input;
    logic [NI*ELEMENT_WIDTH-1:0] adder_row_input;
    logic                        out_valid;
    logic                        row_last;
    logic [15:0]                 row_count;

    modport master (
        output start, in_valid, matrix_row_input, vector_input,
        input  adder_row_input, out_valid, row_last, row_count
    );

    modport slave (
        input  start, in_valid, matrix_row_input, vector_input,
        output adder_row_input, out_valid, row_last, row_count
    );
endinterface

// File: rtl/complex_single_multiplier.sv
// rtl/complex_single_multiplier.sv - one-lane 3-stage Q16.16 complex multiply, data path only
// Build option: COMPLEX_MULT_CONJ_EN multiplies by the conjugate of the vector operand.
module complex_single_multiplier
    import complex_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     en_s1,
    input  logic                     en_s2,
    input  logic                     en_s3,
    input  logic [ELEMENT_WIDTH-1:0] a,
    input  logic [ELEMENT_WIDTH-1:0] x,
    output logic [ELEMENT_WIDTH-1:0] p
);

    complex_t                       x_op;
    complex_t                       a_q;
    complex_t                       x_q;
    logic signed [2*PART_WIDTH-1:0] pp_rr;
    logic signed [2*PART_WIDTH-1:0] pp_ii;
    logic signed [2*PART_WIDTH-1:0] pp_ri;
    logic signed [2*PART_WIDTH-1:0] pp_ir;
    logic signed [2*PART_WIDTH:0]   re_sum;
    logic signed [2*PART_WIDTH:0]   im_sum;

    always_comb begin
        x_op = x;
`ifdef COMPLEX_MULT_CONJ_EN
        x_op.im = -x_op.im;
`endif
    end

    always_comb begin
        re_sum = 65'(pp_rr) - 65'(pp_ii);
        im_sum = 65'(pp_ri) + 65'(pp_ir);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            a_q   <= '0;
            x_q   <= '0;
            pp_rr <= '0;
            pp_ii <= '0;
            pp_ri <= '0;
            pp_ir <= '0;
            p     <= '0;
        end else begin
            if (en_s1) begin
                a_q <= a;
                x_q <= x_op;
            end
            if (en_s2) begin
                pp_rr <= 64'(a_q.re) * 64'(x_q.re);
                pp_ii <= 64'(a_q.im) * 64'(x_q.im);
                pp_ri <= 64'(a_q.re) * 64'(x_q.im);
                pp_ir <= 64'(a_q.im) * 64'(x_q.re);
            end
            if (en_s3) begin
                p[RE_LSB +: PART_WIDTH] <= q_field(re_sum);
                p[IM_LSB +: PART_WIDTH] <= q_field(im_sum);
            end
        end
    end

endmodule

// File: rtl/complex_row_multiplier.sv
// rtl/complex_row_multiplier.sv - NI-lane pipelined complex multiplier feeding the row accumulator
// Build option: COMPLEX_MULT_CONJ_EN (conjugated vector operand in every lane).
module complex_row_multiplier
    import complex_pkg::*;
#(
    parameter int NI             = 8,
    parameter int CHUNKS_PER_ROW = 4
) (
    input logic                     clk,
    input logic                     reset_n,
    complex_row_multiplier_if.slave bus
);

    localparam int               CNT_W      = (CHUNKS_PER_ROW > 1) ? $clog2(CHUNKS_PER_ROW) : 1;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(CHUNKS_PER_ROW - 1);

    logic [CNT_W-1:0]            chunk_cnt;
    logic                        accept;
    logic                        chunk_last;
    logic                        valid_s1;
    logic                        valid_s2;
    logic                        last_s1;
    logic                        last_s2;
    logic                        out_valid;
    logic                        row_last;
    logic [15:0]                 row_count;
    logic [NI*ELEMENT_WIDTH-1:0] products;

    assign accept     = bus.in_valid && bus.start;
    assign chunk_last = (chunk_cnt == LAST_CHUNK);

    // Dropping start flushes control only; lane data registers simply stop loading.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            chunk_cnt <= '0;
            valid_s1  <= 1'b0;
            valid_s2  <= 1'b0;
            last_s1   <= 1'b0;
            last_s2   <= 1'b0;
            out_valid <= 1'b0;
            row_last  <= 1'b0;
            row_count <= '0;
        end else if (!bus.start) begin
            chunk_cnt <= '0;
            valid_s1  <= 1'b0;
            valid_s2  <= 1'b0;
            last_s1   <= 1'b0;
            last_s2   <= 1'b0;
            out_valid <= 1'b0;
            row_last  <= 1'b0;
            row_count <= '0;
        end else begin
            if (bus.in_valid) begin
                chunk_cnt <= chunk_last ? '0 : chunk_cnt + 1'b1;
            end
            valid_s1  <= bus.in_valid;
            last_s1   <= bus.in_valid && chunk_last;
            valid_s2  <= valid_s1;
            last_s2   <= valid_s1 && last_s1;
            out_valid <= valid_s2;
            row_last  <= valid_s2 && last_s2;
            if (valid_s2 && last_s2) begin
                row_count <= row_count + 16'd1;
            end
        end
    end

    for (genvar k = 0; k < NI; k++) begin : g_lane
        complex_single_multiplier u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .en_s1   (accept),
            .en_s2   (valid_s1 && bus.start),
            .en_s3   (valid_s2 && bus.start),
            .a       (bus.matrix_row_input[k*ELEMENT_WIDTH +: ELEMENT_WIDTH]),
            .x       (bus.vector_input[k*ELEMENT_WIDTH +: ELEMENT_WIDTH]),
            .p       (products[k*ELEMENT_WIDTH +: ELEMENT_WIDTH])
        );
    end

    assign bus.adder_row_input = products;
    assign bus.out_valid       = out_valid;
    assign bus.row_last        = row_last;
    assign bus.row_count       = row_count;

endmodule

// File: tb/tb_complex_row_multiplier.sv
// tb/tb_complex_row_multiplier.sv - self-checking bench for complex_row_multiplier (COMPLEX_MULT_CONJ_EN aware)
module tb_complex_row_multiplier;

    localparam int NI   = 8;
    localparam int CPR  = 4;
    localparam int W    = NI * 64;
    localparam int MAXN = 1024;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    complex_row_multiplier_if #(.NI(NI), .ELEMENT_WIDTH(64)) bus0 ();
    complex_row_multiplier_if #(.NI(NI), .ELEMENT_WIDTH(64)) bus1 ();

    assign bus1.start            = bus0.start;
    assign bus1.in_valid         = bus0.in_valid;
    assign bus1.matrix_row_input = bus0.matrix_row_input;
    assign bus1.vector_input     = bus0.vector_input;

    complex_row_multiplier #(.NI(NI), .CHUNKS_PER_ROW(CPR)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus0.slave)
    );

    complex_row_multiplier #(.NI(NI), .CHUNKS_PER_ROW(1)) dut_c1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus1.slave)
    );

    int compared   = 0;
    int mismatched = 0;

    bit           acc_h  [MAXN];
    bit           live_h [MAXN];
    bit           last_h [MAXN];
    logic [W-1:0] prod_h [MAXN];
    int           n        = 0;
    int           cnt4     = 0;
    logic [15:0]  rc4      = '0;
    logic [15:0]  rc1      = '0;
    logic [W-1:0] exp_data = '0;

    typedef struct {
        string       name;
        logic [63:0] a;
        logic [63:0] x;
        logic [63:0] expect_p;
    } vec_t;
    vec_t tbl[6];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    function automatic logic [63:0] ref_elem(input logic [63:0] a, input logic [63:0] x);
        int     ar, ai, xr, xi;
        longint re, im;
        ar = a[63:32];
        ai = a[31:0];
        xr = x[63:32];
        xi = x[31:0];
`ifdef COMPLEX_MULT_CONJ_EN
        xi = -xi;
`endif
        re = (longint'(ar) * longint'(xr) - longint'(ai) * longint'(xi)) >>> 16;
        im = (longint'(ar) * longint'(xi) + longint'(ai) * longint'(xr)) >>> 16;
        return {re[31:0], im[31:0]};
    endfunction

    function automatic logic [W-1:0] ref_row(input logic [W-1:0] a, input logic [W-1:0] x);
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < NI; k++) r[k*64 +: 64] = ref_elem(a[k*64 +: 64], x[k*64 +: 64]);
        return r;
    endfunction

    function automatic logic [W-1:0] rand_row();
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < 2 * NI; k++) begin
            case ($urandom_range(0, 9))
                0:       r[k*32 +: 32] = 32'h8000_0000;
                1:       r[k*32 +: 32] = 32'h7FFF_FFFF;
                2:       r[k*32 +: 32] = 32'h0000_0000;
                default: r[k*32 +: 32] = $urandom;
            endcase
        end
        return r;
    endfunction

    // One clock: drive at negedge, predict from the input history, compare 1 ns after posedge.
    task automatic step(input bit rn, input bit st, input bit iv, input logic [W-1:0] a, input logic [W-1:0] x);
        bit ev;
        bit el;
        @(negedge clk);
        reset_n               = rn;
        bus0.start            = st;
        bus0.in_valid         = iv;
        bus0.matrix_row_input = a;
        bus0.vector_input     = x;
        if (n >= MAXN) begin
            $display("FAIL history_overflow: actual %0d required below %0d", n, MAXN);
            $fatal(1, "history exhausted");
        end
        acc_h[n]  = rn && st && iv;
        live_h[n] = rn && st;
        last_h[n] = 1'b0;
        if (!rn || !st) cnt4 = 0;
        else if (iv) begin
            last_h[n] = (cnt4 == CPR - 1);
            cnt4      = (cnt4 + 1) % CPR;
        end
        prod_h[n] = ref_row(a, x);
        @(posedge clk);
        #1;
        ev = (n >= 2) && acc_h[n-2] && live_h[n-1] && live_h[n];
        el = ev && last_h[n-2];
        if (!rn) begin
            exp_data = '0;
            rc4      = '0;
            rc1      = '0;
        end else if (!st) begin
            rc4 = '0;
            rc1 = '0;
        end else if (ev) begin
            exp_data = prod_h[n-2];
            if (el) rc4 = rc4 + 16'd1;
            rc1 = rc1 + 16'd1;
        end
        check($sformatf("out_valid@%0d", n), W'(bus0.out_valid), W'(ev));
        check($sformatf("row_last@%0d", n), W'(bus0.row_last), W'(el));
        check($sformatf("row_count@%0d", n), W'(bus0.row_count), W'(rc4));
        check($sformatf("adder_row_input@%0d", n), bus0.adder_row_input, exp_data);
        check($sformatf("c1_out_valid@%0d", n), W'(bus1.out_valid), W'(ev));
        check($sformatf("c1_row_last@%0d", n), W'(bus1.row_last), W'(ev));
        check($sformatf("c1_row_count@%0d", n), W'(bus1.row_count), W'(rc1));
        n++;
    endtask

    task automatic restart();
        step(1'b1, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        bit [9:0]     pat;
        bit [9:0]     vb;
        bit [9:0]     lb;
        bit [7:0]     lastpat;
        bit [3:0]     lp4;
        int           ob;
        int           vsum;
        logic [W-1:0] ra;
        logic [W-1:0] rx;

        tbl[0] = '{"mul_1p2i_3p4i", 64'h00010000_00020000, 64'h00030000_00040000,
`ifdef COMPLEX_MULT_CONJ_EN
                   64'h000B0000_00020000};
`else
                   64'hFFFB0000_000A0000};
`endif
        tbl[1] = '{"overflow_wrap", 64'h7FFF0000_00000000, 64'h7FFF0000_00000000, 64'h00010000_00000000};
        tbl[2] = '{"neg_one_times_half", 64'hFFFF0000_00000000, 64'h00008000_00008000,
`ifdef COMPLEX_MULT_CONJ_EN
                   64'hFFFF8000_00008000};
`else
                   64'hFFFF8000_FFFF8000};
`endif
        tbl[3] = '{"floor_positive", 64'h00000001_00000000, 64'h00008000_00000000, 64'h00000000_00000000};
        tbl[4] = '{"floor_negative", 64'hFFFFFFFF_00000000, 64'h00008000_00000000, 64'hFFFFFFFF_00000000};
        tbl[5] = '{"imag_min_edge", 64'h00010000_00000000, 64'h00010000_80000000, 64'h00010000_80000000};

        reset_n               = 1'b0;
        bus0.start            = 1'b0;
        bus0.in_valid         = 1'b0;
        bus0.matrix_row_input = '0;
        bus0.vector_input     = '0;

        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, '0, '0);
        check("reset_adder", bus0.adder_row_input, '0);
        check("reset_out_valid", W'(bus0.out_valid), '0);
        check("reset_row_count", W'(bus0.row_count), '0);

        // table vectors: identical element in every lane, exact 3-cycle latency
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, 1'b1, {NI{tbl[i].a}}, {NI{tbl[i].x}});
            step(1'b1, 1'b1, 1'b0, '0, '0);
            check({tbl[i].name, "_early"}, W'(bus0.out_valid), '0);
            step(1'b1, 1'b1, 1'b0, '0, '0);
            check({tbl[i].name, "_valid"}, W'(bus0.out_valid), W'(1));
            check(tbl[i].name, bus0.adder_row_input, {NI{tbl[i].expect_p}});
        end

        // eight back-to-back beats: two full rows
        restart();
        ob      = 0;
        lastpat = '0;
        for (int i = 0; i < 11; i++) begin
            step(1'b1, 1'b1, i < 8, rand_row(), rand_row());
            if (bus0.out_valid && ob < 8) begin
                lastpat[ob] = bus0.row_last;
                ob++;
            end
        end
        check("b2b_beats", W'(ob), W'(8));
        check("b2b_row_last", W'(lastpat), W'(8'b1000_1000));
        check("b2b_row_count", W'(bus0.row_count), W'(2));

        // valid, gap, valid, gap, gap, valid, valid: the fourth beat closes the row
        restart();
        pat = 10'b00_0110_0101;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, pat[i], rand_row(), rand_row());
            vb[i] = bus0.out_valid;
            lb[i] = bus0.row_last;
        end
        check("gap_out_valid", W'(vb), W'(pat << 2));
        check("gap_row_last", W'(lb), W'(10'b01_0000_0000));

        // start dropped with two beats in flight
        restart();
        step(1'b1, 1'b1, 1'b1, rand_row(), rand_row());
        step(1'b1, 1'b1, 1'b1, rand_row(), rand_row());
        vsum = 0;
        step(1'b1, 1'b0, 1'b1, rand_row(), rand_row());
        vsum += bus0.out_valid;
        step(1'b1, 1'b0, 1'b0, '0, '0);
        vsum += bus0.out_valid;
        check("drop_no_valid", W'(vsum), '0);
        check("drop_row_count", W'(bus0.row_count), '0);
        ob  = 0;
        lp4 = '0;
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 1'b1, i < 4, rand_row(), rand_row());
            if (i < 2) vsum += bus0.out_valid;
            if (bus0.out_valid && ob < 4) begin
                lp4[ob] = bus0.row_last;
                ob++;
            end
        end
        check("drop_flushed", W'(vsum), '0);
        check("restart_row_last", W'(lp4), W'(4'b1000));
        check("restart_row_count", W'(bus0.row_count), W'(1));

        // reset in the middle of a stream
        restart();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, rand_row(), rand_row());
        step(1'b0, 1'b1, 1'b1, rand_row(), rand_row());
        check("midreset_adder", bus0.adder_row_input, '0);
        check("midreset_out_valid", W'(bus0.out_valid), '0);
        check("midreset_row_last", W'(bus0.row_last), '0);
        check("midreset_row_count", W'(bus0.row_count), '0);

        // randomized traffic against the history model
        for (int i = 0; i < 500; i++) begin
            ra = rand_row();
            rx = rand_row();
            step($urandom_range(0, 63) != 0, $urandom_range(0, 15) != 0,
                 $urandom_range(0, 3) != 0, ra, rx);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
